receiver_spi: RTL and testbench
===============================

RECEIVER_SPI -- requirements
Module: receiver_spi

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on SCK/CS/MOSI (minimum 2).
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port CKP, input, 1, SCK idle polarity (0 idle low, 1 idle high).
REQ-005 SHALL have port CPH, input, 1, sample edge select (0 rising SCK, 1 falling SCK).
REQ-006 SHALL have port SCK, input, 1, serial clock from the master.
REQ-007 SHALL have port CS, input, 1, chip select, active-low.
REQ-008 SHALL have port MOSI, input, 1, serial data from the master, LSB first.
REQ-009 SHALL have port data_tx, input, 8, byte returned to the master on MISO.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-011 SHALL have port MISO, output, 1, serial data to the master, LSB first.
REQ-012 SHALL have port rx_data, output, 8, last received byte.
REQ-013 SHALL have port rx_valid, output, 1, rx_data holds an unconsumed byte.
REQ-014 SHALL have port overrun, output, 1, sticky: a byte was lost.
REQ-015 SHALL have port frame_err, output, 1, one-cycle pulse on a partial-byte abort.
REQ-016 SHALL have port busy, output, 1, high while in state SHIFT.

Function
REQ-017 SHALL pass SCK, CS and MOSI through SYNC_STAGES flops, then detect edges by comparison with a one-cycle-delayed copy.
REQ-018 SHALL implement states IDLE (CS high) and SHIFT (CS low); IDLE->SHIFT on synchronized CS fall; SHIFT->IDLE on synchronized CS rise.
REQ-019 SHALL load tx_shift from data_tx and clear bit_cnt on IDLE->SHIFT.
REQ-020 SHALL sample MOSI into the MSB of rx_shift while shifting right, on the CPH-selected SCK edge; shift tx_shift right on the same edge; increment bit_cnt (3-bit, wraps 7->0).
REQ-021 SHALL drive MISO = tx_shift[0] in SHIFT and 0 in IDLE.
REQ-022 SHALL ignore SCK edges while in IDLE; CKP affects nothing beyond documentation of idle level.
REQ-023 SHALL complete a byte when bit_cnt wraps 7->0; SHALL assert rx_valid SYNC_STAGES+1 clk cycles after the eighth sampling edge on the SCK pin.
REQ-024 SHALL reload tx_shift from data_tx on byte completion while CS stays low (back-to-back bytes).
REQ-025 SHALL hold rx_valid and rx_data until a cycle with rx_valid && rx_ready.
REQ-026 SHALL, when a byte completes while the holding stage is full and rx_ready is low, drop the new byte, keep rx_data and set overrun.
REQ-027 SHALL, on byte completion coincident with rx_valid && rx_ready, accept the new byte with no overrun.
REQ-028 SHALL, when CS rises with bit_cnt != 0, discard the partial byte and pulse frame_err for one cycle.

Reset
REQ-029 SHALL on rst low at a clk edge force state IDLE, bit_cnt 0, shift registers 0, MISO 0, rx_data 0, rx_valid 0, overrun 0, frame_err 0, busy 0, and synchronizers to CS=1, SCK=CKP, MOSI=0.
REQ-030 SHALL, on reset during SHIFT, abort the frame without a frame_err pulse and ignore SCK until the next CS fall.

Configuration
REQ-031 SHALL, with RECEIVER_SPI_FIFO_EN defined, buffer completed bytes in a 4-entry FIFO: rx_valid = not empty, rx_data = head, overrun only when full.
REQ-032 SHALL, without RECEIVER_SPI_FIFO_EN, use the single holding register of REQ-025..027.

Structure
REQ-033 SHALL take the state encoding, DATA_W=8 and FIFO_DEPTH=4 from shared package spi_pkg.
REQ-034 SHALL instantiate sub-module spi_sync (parameterized N-flop synchronizer) for each of SCK, CS and MOSI.

Verification
REQ-035 SHALL cover mode CPH=0 with master sending 0xA5 and data_tx=0x3C: rx_data=0xA5 and rx_valid rise, and MISO serializes 0x3C LSB first.
REQ-036 SHALL cover mode CPH=1, CKP=1 with bytes 0x81 then 0x7E under one CS: two rx_valid handshakes in order and no frame_err.
REQ-037 SHALL cover CS rising after 5 bits: frame_err pulses once, rx_valid stays 0 and bit_cnt restarts at 0.
REQ-038 SHALL cover rx_ready held low across 2 bytes (no FIFO): the first byte is retained and overrun=1; with FIFO, 5 bytes are needed to set overrun.
REQ-039 SHALL cover rx_ready high in the completion cycle: the new byte is accepted and overrun stays 0.
REQ-040 SHALL cover rst low mid-byte: all outputs reach reset values, then a clean 0x5A frame is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and sizing for the SPI receiver: FSM state encoding, data width
// and receive FIFO depth.
package spi_pkg;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(DATA_W);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous input; the reset value is an input
// so each line can come out of reset at its own idle level.
module spi_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);
  logic [N-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (!rst) chain_reg <= {N{rst_val}};
    else      chain_reg <= {chain_reg[N-2:0], d};
  end

  assign q = chain_reg[N-1];
endmodule

// File: rtl/receiver_spi.sv
// SPI slave receiver, LSB first, oversampled on clk. Define RECEIVER_SPI_FIFO_EN
// to buffer completed bytes in a small FIFO instead of a single holding register.
module receiver_spi
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CKP,
  input  logic              CPH,
  input  logic              SCK,
  input  logic              CS,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] data_tx,
  input  logic              rx_ready,
  output logic              MISO,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);
  // Bit order in the pin vectors: 0 = SCK, 1 = CS, 2 = MOSI
  logic [2:0] pin_raw, pin_rst, pin_sync;
  assign pin_raw = {MOSI, CS, SCK};
  assign pin_rst = {1'b0, 1'b1, CKP};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync #(.N(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .rst_val (pin_rst[gi]),
        .d       (pin_raw[gi]),
        .q       (pin_sync[gi])
      );
    end
  endgenerate

  logic sck_s, cs_s, mosi_s;
  assign sck_s  = pin_sync[0];
  assign cs_s   = pin_sync[1];
  assign mosi_s = pin_sync[2];

  logic                   sck_d_reg, cs_d_reg;
  logic [SYNC_STAGES-1:0] flush_reg;
  logic                   armed_reg;
  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]      rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0]      tx_shift_reg, tx_shift_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   byte_done;
  logic [DATA_W-1:0]      rx_byte;

  logic sck_rise, sck_fall, sample_edge, cs_fall, cs_rise;
  assign sck_rise    = sck_s & ~sck_d_reg;
  assign sck_fall    = ~sck_s & sck_d_reg;
  assign sample_edge = CPH ? sck_fall : sck_rise;
  // A CS fall only counts once the synchronizer has shown CS high after reset,
  // so a frame already in progress at reset release is ignored.
  assign cs_fall     = cs_d_reg & ~cs_s & armed_reg;
  assign cs_rise     = cs_s & ~cs_d_reg;
  assign rx_byte     = {mosi_s, rx_shift_reg[DATA_W-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_d_reg     <= CKP;
      cs_d_reg      <= 1'b1;
      flush_reg     <= '0;
      armed_reg     <= 1'b0;
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      rx_shift_reg  <= '0;
      tx_shift_reg  <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      sck_d_reg     <= sck_s;
      cs_d_reg      <= cs_s;
      flush_reg     <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
      armed_reg     <= armed_reg | (flush_reg[SYNC_STAGES-1] & cs_s);
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    frame_err_next = 1'b0;
    byte_done      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          state_next    = SHIFT;
          tx_shift_next = data_tx;
          bit_cnt_next  = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next     = IDLE;
          frame_err_next = (bit_cnt_reg != '0);
        end else if (sample_edge) begin
          rx_shift_next = rx_byte;
          tx_shift_next = tx_shift_reg >> 1;
          bit_cnt_next  = bit_cnt_reg + CNT_W'(1);
          if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
            byte_done     = 1'b1;
            tx_shift_next = data_tx;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign MISO      = (state_reg == SHIFT) & tx_shift_reg[0];
  assign busy      = (state_reg == SHIFT);
  assign frame_err = frame_err_reg;

  logic pop;
  assign pop = rx_valid & rx_ready;

`ifdef RECEIVER_SPI_FIFO_EN
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              full, push;

  assign full = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = byte_done & (~full | pop);

  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (!rst)                                   fifo_mem[gi] <= '0;
        else if (push && wr_ptr_reg == PTR_W'(gi))  fifo_mem[gi] <= rx_byte;
      end
    end
  endgenerate

  logic overrun_reg;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
      if (byte_done && !push) overrun_reg <= 1'b1;
    end
  end

  assign rx_valid = (count_reg != '0);
  assign rx_data  = fifo_mem[rd_ptr_reg];
  assign overrun  = overrun_reg;
`else
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg, overrun_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      overrun_reg  <= 1'b0;
    end else if (byte_done) begin
      if (!rx_valid_reg || pop) begin
        rx_data_reg  <= rx_byte;
        rx_valid_reg <= 1'b1;
      end else begin
        overrun_reg  <= 1'b1;
      end
    end else if (pop) begin
      rx_valid_reg <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_reg;
  assign rx_data  = rx_data_reg;
  assign overrun  = overrun_reg;
`endif
endmodule

// File: tb/tb_receiver_spi.sv
// Directed bench for receiver_spi: SPI modes 0 and 3, back-to-back bytes,
// partial-frame abort, overrun, coincident accept and mid-frame reset.
module tb_receiver_spi;
  localparam int HALF = 8;
`ifdef RECEIVER_SPI_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk, rst, CKP, CPH, SCK, CS, MOSI, rx_ready;
  logic [7:0] data_tx;
  logic       MISO, rx_valid, overrun, frame_err, busy;
  logic [7:0] rx_data;

  int         checks   = 0;
  int         failures = 0;
  int         fe_cnt   = 0;
  int         fe_base;
  int         hs_base;
  logic [7:0] hs_q[$];
  logic [7:0] miso_cap;
  logic       sck_idle;
  bit         lat_chk, ready_at_done;

  receiver_spi #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .CKP(CKP), .CPH(CPH), .SCK(SCK), .CS(CS),
    .MOSI(MOSI), .data_tx(data_tx), .rx_ready(rx_ready), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake log and frame_err cycle count, sampled on the active edge.
  always @(posedge clk) begin
    if (rst && rx_valid && rx_ready) hs_q.push_back(rx_data);
    if (frame_err) fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      MOSI = b[i];
      tick(HALF);
      miso_cap[i] = MISO;
      SCK = ~sck_idle;
      if (i == 7 && (lat_chk || ready_at_done)) begin
        tick(1);
        if (lat_chk) check("lat_cyc1", rx_valid, 1'b0);
        tick(1);
        if (lat_chk) check("lat_cyc2", rx_valid, 1'b0);
        if (ready_at_done) rx_ready = 1'b1;
        tick(1);
        if (lat_chk) check("lat_cyc3", rx_valid, 1'b1);
        if (ready_at_done) rx_ready = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      SCK = sck_idle;
    end
  endtask

  task automatic frame(input logic [7:0] b);
    CS = 1'b0;
    tick(HALF);
    send_bits(b, 8);
    CS = 1'b1;
    tick(HALF);
  endtask

  initial begin
    rst = 1'b0; CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; CS = 1'b1; MOSI = 1'b0;
    data_tx = 8'h00; rx_ready = 1'b0; sck_idle = 1'b0;
    lat_chk = 1'b0; ready_at_done = 1'b0; miso_cap = 8'h00;
    tick(4);
    check("rst_miso", MISO, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(6);

    // Mode 0: receive 0xA5 while returning 0x3C
    fe_base = fe_cnt;
    data_tx = 8'h3C;
    CS = 1'b0;
    tick(HALF);
    check("m0_busy", busy, 1'b1);
    lat_chk = 1'b1;
    send_bits(8'hA5, 8);
    lat_chk = 1'b0;
    check("m0_rx_data", rx_data, 8'hA5);
    check("m0_miso", miso_cap, 8'h3C);
    CS = 1'b1;
    tick(HALF);
    check("m0_busy_off", busy, 1'b0);
    check("m0_no_fe", fe_cnt - fe_base, 0);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    check("m0_popped", rx_valid, 1'b0);

    // Mode 3: two bytes under one CS, second byte reloads data_tx
    CKP = 1'b1; CPH = 1'b1; SCK = 1'b1; sck_idle = 1'b1;
    tick(4);
    rx_ready = 1'b1;
    hs_base = hs_q.size();
    fe_base = fe_cnt;
    data_tx = 8'h96;
    CS = 1'b0;
    tick(HALF);
    data_tx = 8'h5B;
    send_bits(8'h81, 8);
    check("m3_miso_b0", miso_cap, 8'h96);
    send_bits(8'h7E, 8);
    check("m3_miso_b1", miso_cap, 8'h5B);
    CS = 1'b1;
    tick(HALF);
    rx_ready = 1'b0;
    check("m3_hs_count", hs_q.size() - hs_base, 2);
    check("m3_hs_first", hs_q[hs_base], 8'h81);
    check("m3_hs_second", hs_q[hs_base + 1], 8'h7E);
    check("m3_no_fe", fe_cnt - fe_base, 0);

    // Partial byte abort after 5 bits, then a full frame from bit 0
    CKP = 1'b0; CPH = 1'b0; SCK = 1'b0; sck_idle = 1'b0;
    tick(4);
    fe_base = fe_cnt;
    CS = 1'b0;
    tick(HALF);
    send_bits(8'h1F, 5);
    CS = 1'b1;
    tick(HALF);
    check("abort_fe_pulse", fe_cnt - fe_base, 1);
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    frame(8'hC3);
    check("after_abort_data", rx_data, 8'hC3);
    check("after_abort_valid", rx_valid, 1'b1);
    check("after_abort_ovr", overrun, 1'b0);

    // Overrun with rx_ready held low; C3 already held
    begin
      logic [7:0] extra [4];
      extra[0] = 8'h11; extra[1] = 8'h22; extra[2] = 8'h33; extra[3] = 8'h44;
      for (int k = 0; k < 4; k++) begin
        frame(extra[k]);
        check($sformatf("ovr_flag_%0d", k + 2), overrun, (k + 2) > CAP);
        check($sformatf("ovr_head_%0d", k + 2), rx_data, 8'hC3);
      end
    end

    // Reset in the middle of a byte, SCK ignored until a fresh CS fall
    fe_base = fe_cnt;
    CS = 1'b0;
    tick(HALF);
    send_bits(8'hFF, 3);
    rst = 1'b0;
    tick(2);
    check("mid_rst_miso", MISO, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_rx_valid", rx_valid, 1'b0);
    check("mid_rst_overrun", overrun, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick(4);
    send_bits(8'hFF, 3);
    check("post_rst_busy", busy, 1'b0);
    CS = 1'b1;
    tick(HALF);
    check("post_rst_no_fe", fe_cnt - fe_base, 0);
    frame(8'h5A);
    check("clean_rx_data", rx_data, 8'h5A);
    check("clean_rx_valid", rx_valid, 1'b1);

    // Completion coincident with rx_valid && rx_ready
    CS = 1'b0;
    tick(HALF);
    ready_at_done = 1'b1;
    send_bits(8'h66, 8);
    ready_at_done = 1'b0;
    CS = 1'b1;
    tick(HALF);
    check("coinc_rx_data", rx_data, 8'h66);
    check("coinc_rx_valid", rx_valid, 1'b1);
    check("coinc_overrun", overrun, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
